nametable_update_sched: RTL and testbench
=========================================

Name: nametable_update_sched

Overview:
- Sole owner of the single-port background name table RAM (240 words x 32 bit, 4 tile indices per word).
- The background tile draw logic has an unconditional read path through it.
- CPU-side writes and a whole-table clear command are buffered and committed only inside the vertical blank window, so the picture never tears mid-frame.
- Sits between the AHB peripheral write path and the name table RAM, next to the background draw logic.

Parameters:
- FIFO_DEPTH, 8, write-buffer entries (power of 2)
- POSXY_BIT, 10, VGA coordinate width
- GAME_START_POSY, 0, first displayed game line
- GAME_HEIGHT, 240, displayed game lines
- NT_WORDS, 240, valid name table word addresses 0..NT_WORDS-1

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- vga_pos_y  in  POSXY_BIT  current VGA line, already synchronous to clk
- cpu_wr_valid  in  1  write request
- cpu_wr_ready  out  1  write accepted this cycle when valid&ready
- cpu_wr_addr  in  8  word address
- cpu_wr_data  in  32  word data; byte 3 = leftmost tile
- cpu_wr_be  in  4  byte enables
- clr_req  in  1  single-cycle clear request
- clr_value  in  8  tile index written to every byte on clear; sampled with clr_req
- clr_busy  out  1  clear pending or running
- draw_addr  in  8  read address from the background draw logic
- ram_addr  out  8  RAM address
- ram_wdata  out  32  RAM write data
- ram_be  out  4  RAM byte enables
- ram_we  out  1  RAM write strobe
- fifo_level  out  clog2(FIFO_DEPTH+1)  entries buffered
- addr_err  out  1  one-cycle pulse: accepted write had addr >= NT_WORDS and was discarded

Behaviour:
- Reset (async, rstn=0):
  - ram_we=0; ram_wdata=0; ram_be=0.
  - fifo_level=0; clr_busy=0; addr_err=0.
  - FSM=IDLE; FIFO pointers cleared.
- Address mux: ram_addr = ram_we ? wr_addr_q : draw_addr (combinational). The read path has zero added latency whenever no write is issued.
- Issue window, combinational: issue_ok = (vga_pos_y < GAME_START_POSY-1) OR (vga_pos_y >= GAME_START_POSY+GAME_HEIGHT).
  - Line GAME_START_POSY-1 is a guard line, so no registered write lands on an active line.
  - With GAME_START_POSY=0 the first term is false.
- cpu_wr_ready = !fifo_full && !clr_busy.
- On handshake:
  - addr >= NT_WORDS: not stored; addr_err=1 the next cycle.
  - Otherwise: pushed, and fifo_level increments the next cycle.
- FSM states: IDLE, DRAIN, CLEAR.
  - IDLE:
    - if clr pending and FIFO empty -> CLEAR, clear counter=0;
    - else if FIFO non-empty -> DRAIN.
  - DRAIN: each cycle with issue_ok and FIFO non-empty, pop one entry. Next cycle: ram_we=1 with that entry's addr/data/be; fifo_level decrements. When FIFO is empty -> IDLE.
  - CLEAR: each cycle with issue_ok:
    - next cycle ram_we=1, wr_addr_q=counter, ram_wdata={4{clr_value_q}}, ram_be=4'hF;
    - counter increments.
    - After the write of address NT_WORDS-1 -> IDLE and clr_busy drops the same cycle.
  - Outside issue_ok, DRAIN/CLEAR hold state, counter and FIFO unchanged (pause), and ram_we=0. Work resumes in the next blank.
  - Throughput: 1 write/cycle in window. Latency from handshake to ram_we is >= 2 cycles.
- Clear ordering:
  - clr_req sets clr_busy the next cycle and latches clr_value.
  - Writes already in the FIFO drain first, then CLEAR runs.
  - No new writes are accepted until the clear completes.
  - clr_req while clr_busy=1 is ignored.
- Simultaneous clr_req and write handshake in the same cycle: the write is accepted (ready was 1) and ordered before the clear.
- FIFO full: ready=0; no overwrite. Push and pop in the same cycle leave fifo_level unchanged.
- Reset mid-operation: all pending writes and any clear in progress are discarded; ram_we drops immediately.

Test Plan:
- Reset: rstn low mid-DRAIN with 3 entries -> ram_we=0 immediately, fifo_level=0, clr_busy=0, cpu_wr_ready=1 after release.
- Active-line write: vga_pos_y=100, write addr=5, data=32'h01020304, be=4'hF -> no ram_we while y<240. At y=240, ram_we pulses once with ram_addr=5, ram_wdata=32'h01020304. ram_addr equals draw_addr in every other cycle.
- Blank write: y=250, write addr=10 be=4'b0100 at cycle N -> ram_we=1 at cycle N+2, ram_be=4'b0100, fifo_level back to 0.
- Full FIFO: y=50, 9 back-to-back writes -> 8 accepted, cpu_wr_ready=0 on the 9th, fifo_level=8. At y=240 there are 8 consecutive ram_we cycles in FIFO order.
- Clear spanning blank end: clr_req with clr_value=8'h2A, issued 100 cycles before the guard line (GAME_START_POSY=16) -> 100 writes to addr 0..99 of 32'h2A2A2A2A, then paused. The clear resumes at 100 in the next blank, completes at 239, then clr_busy=0.
- Bad address plus simultaneous clear: write addr=240 -> addr_err one cycle, no ram_we. Write addr=3 together with clr_req -> addr 3 written first, then full clear, and cpu_wr_ready=0 throughout.

Source files
------------

// File: rtl/nametable_update_sched.sv
// nametable_update_sched
// ----------------------
// Owns the single-port background name table RAM (240 x 32 bit, four tile
// indices per word, byte 3 = leftmost tile). The background draw logic reads
// straight through whenever no write is being issued. CPU writes and the
// whole-table clear command are queued and committed only while the beam is
// outside the displayed game area, so a frame never shows a half-updated table.
//
// Ports:
//   clk, rstn             clock, asynchronous active-low reset
//   vga_pos_y             current VGA line (already synchronous to clk)
//   cpu_wr_*              write request channel (valid/ready handshake)
//   clr_req, clr_value    single-cycle clear command and its fill tile index
//   clr_busy              a clear is pending or running
//   draw_addr             read address from the background draw logic
//   ram_addr/wdata/be/we  name table RAM port
//   fifo_level            number of buffered writes
//   addr_err              one-cycle pulse when an out-of-range write was dropped
module nametable_update_sched #(
  parameter int FIFO_DEPTH      = 8,
  parameter int POSXY_BIT       = 10,
  parameter int GAME_START_POSY = 0,
  parameter int GAME_HEIGHT     = 240,
  parameter int NT_WORDS        = 240,
  localparam int LEVEL_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [POSXY_BIT-1:0] vga_pos_y,
  input  logic                 cpu_wr_valid,
  output logic                 cpu_wr_ready,
  input  logic [7:0]           cpu_wr_addr,
  input  logic [31:0]          cpu_wr_data,
  input  logic [3:0]           cpu_wr_be,
  input  logic                 clr_req,
  input  logic [7:0]           clr_value,
  output logic                 clr_busy,
  input  logic [7:0]           draw_addr,
  output logic [7:0]           ram_addr,
  output logic [31:0]          ram_wdata,
  output logic [3:0]           ram_be,
  output logic                 ram_we,
  output logic [LEVEL_W-1:0]   fifo_level,
  output logic                 addr_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // The guard line just before the game area only exists when the game area
  // does not start at line 0; otherwise "start - 1" would wrap to all ones.
  localparam bit          HAS_PRE_BLANK = (GAME_START_POSY > 0);
  localparam logic [31:0] GUARD_Y       = 32'(GAME_START_POSY - 1);
  localparam logic [31:0] END_Y         = 32'(GAME_START_POSY + GAME_HEIGHT);
  localparam logic [31:0] NT_WORDS_U    = 32'(NT_WORDS);
  localparam logic [7:0]  LAST_ADDR     = 8'(NT_WORDS - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_entry_t;

  wr_entry_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LEVEL_W-1:0]   fifo_level_reg;
  state_t               state_reg;
  logic [7:0]           clr_cnt_reg;
  logic [7:0]           clr_value_reg;
  logic                 clr_busy_reg;
  logic                 ram_we_reg;
  logic [7:0]           wr_addr_reg;
  logic [31:0]          ram_wdata_reg;
  logic [3:0]           ram_be_reg;
  logic                 addr_err_reg;

  logic [31:0] pos_y_ext;
  logic        issue_ok;
  logic        fifo_empty, fifo_full;
  logic        handshake, addr_ok, push, pop;
  logic [31:0] clr_word;

  assign pos_y_ext = 32'(vga_pos_y);
  assign issue_ok  = (HAS_PRE_BLANK && (pos_y_ext < GUARD_Y)) || (pos_y_ext >= END_Y);

  assign fifo_empty   = (fifo_level_reg == '0);
  assign fifo_full    = (fifo_level_reg == LEVEL_W'(FIFO_DEPTH));
  assign cpu_wr_ready = !fifo_full && !clr_busy_reg;

  assign handshake = cpu_wr_valid && cpu_wr_ready;
  assign addr_ok   = (32'(cpu_wr_addr) < NT_WORDS_U);
  assign push      = handshake && addr_ok;
  assign pop       = (state_reg == DRAIN) && issue_ok && !fifo_empty;

  // Clear pattern: the latched tile index replicated into every byte lane.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_clr_lane
      assign clr_word[8*gi +: 8] = clr_value_reg;
    end
  endgenerate

  // Write buffer storage; contents need no reset since the pointers gate use.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= '{addr: cpu_wr_addr, data: cpu_wr_data, be: cpu_wr_be};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_level_reg <= '0;
      state_reg      <= IDLE;
      clr_cnt_reg    <= '0;
      clr_value_reg  <= '0;
      clr_busy_reg   <= 1'b0;
      ram_we_reg     <= 1'b0;
      wr_addr_reg    <= '0;
      ram_wdata_reg  <= '0;
      ram_be_reg     <= '0;
      addr_err_reg   <= 1'b0;
    end else begin
      ram_we_reg   <= 1'b0;
      addr_err_reg <= handshake && !addr_ok;

      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);

      case ({push, pop})
        2'b10:   fifo_level_reg <= fifo_level_reg + LEVEL_W'(1);
        2'b01:   fifo_level_reg <= fifo_level_reg - LEVEL_W'(1);
        default: fifo_level_reg <= fifo_level_reg;
      endcase

      // A clear request during a pending/running clear is dropped.
      if (clr_req && !clr_busy_reg) begin
        clr_busy_reg  <= 1'b1;
        clr_value_reg <= clr_value;
      end

      case (state_reg)
        IDLE: begin
          // Buffered writes always go out before a pending clear.
          if (clr_busy_reg && fifo_empty) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
          end else if (!fifo_empty) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop) begin
            ram_we_reg    <= 1'b1;
            wr_addr_reg   <= fifo_mem[rd_ptr_reg].addr;
            ram_wdata_reg <= fifo_mem[rd_ptr_reg].data;
            ram_be_reg    <= fifo_mem[rd_ptr_reg].be;
          end else if (fifo_empty) begin
            state_reg <= IDLE;
          end
        end
        CLEAR: begin
          if (issue_ok) begin
            ram_we_reg    <= 1'b1;
            wr_addr_reg   <= clr_cnt_reg;
            ram_wdata_reg <= clr_word;
            ram_be_reg    <= 4'hF;
            if (clr_cnt_reg == LAST_ADDR) begin
              // Busy drops together with the final write strobe.
              state_reg    <= IDLE;
              clr_busy_reg <= 1'b0;
            end else begin
              clr_cnt_reg <= clr_cnt_reg + 8'd1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // The draw logic owns the RAM address except in cycles carrying a write.
  assign ram_addr   = ram_we_reg ? wr_addr_reg : draw_addr;
  assign ram_we     = ram_we_reg;
  assign ram_wdata  = ram_wdata_reg;
  assign ram_be     = ram_be_reg;
  assign clr_busy   = clr_busy_reg;
  assign fifo_level = fifo_level_reg;
  assign addr_err   = addr_err_reg;

endmodule

// File: tb/tb_nametable_update_sched.sv
// Testbench for nametable_update_sched: random and directed stimulus against a
// queue-based reference of the RAM write stream, with a separate monitor that
// pops and compares every RAM write and checks status outputs each cycle.
module tb_nametable_update_sched;

  localparam int GSP    = 0;
  localparam int GH     = 240;
  localparam int NTW    = 240;
  localparam int DEPTH  = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic [9:0]  vga_pos_y;
  logic        cpu_wr_valid;
  logic        cpu_wr_ready;
  logic [7:0]  cpu_wr_addr;
  logic [31:0] cpu_wr_data;
  logic [3:0]  cpu_wr_be;
  logic        clr_req;
  logic [7:0]  clr_value;
  logic        clr_busy;
  logic [7:0]  draw_addr;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic        ram_we;
  logic [3:0]  fifo_level;
  logic        addr_err;

  nametable_update_sched dut (
    .clk(clk), .rstn(rstn), .vga_pos_y(vga_pos_y),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
    .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data), .cpu_wr_be(cpu_wr_be),
    .clr_req(clr_req), .clr_value(clr_value), .clr_busy(clr_busy),
    .draw_addr(draw_addr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_be(ram_be), .ram_we(ram_we), .fifo_level(fifo_level), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    bit          clr;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   pushed = 0;      // accepted in-range CPU writes
  int   popped = 0;      // CPU writes seen on the RAM port
  int   clr_rem = 0;     // clear writes still owed
  int   clr_seen = 0;    // clear writes seen on the RAM port
  bit   exp_err = 1'b0;
  bit   last_ok = 1'b0;

  function automatic bit in_blank(input int y);
    return (y < GSP - 1) || (y >= GSP + GH);
  endfunction

  function automatic bit model_ready();
    return ((pushed - popped) < DEPTH) && (clr_rem == 0);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pushed = 0; popped = 0; clr_rem = 0; exp_err = 1'b0;
  endtask

  // Window in force at the edge just taken.
  always @(posedge clk) last_ok = in_blank(int'(vga_pos_y));

  // Monitor: compares the RAM write stream and status outputs every cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (ram_we) begin
        chk("write_in_window", 64'(last_ok), 64'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {ram_addr, ram_wdata, ram_be}, 64'd0 - 64'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ram_write", {ram_addr, ram_wdata, ram_be}, {e.addr, e.data, e.be});
          if (e.clr) begin clr_rem--; clr_seen++; end
          else popped++;
        end
      end else begin
        chk("ram_addr_mux", 64'(ram_addr), 64'(draw_addr));
      end
      chk("fifo_level", 64'(fifo_level), 64'(pushed - popped));
      chk("clr_busy", 64'(clr_busy), 64'(clr_rem > 0));
      chk("cpu_wr_ready", 64'(cpu_wr_ready), 64'(model_ready()));
      chk("addr_err", 64'(addr_err), 64'(exp_err));
    end
  end

  // One clock of stimulus: drive inputs, take the edge, update the model.
  task automatic step(input bit v, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] be, input bit clr, input logic [7:0] cv,
                      input int y);
    bit acc;
    cpu_wr_valid = v; cpu_wr_addr = a; cpu_wr_data = d; cpu_wr_be = be;
    clr_req = clr; clr_value = cv; vga_pos_y = y[9:0];
    draw_addr = 8'($urandom);
    acc = v && model_ready();
    @(posedge clk);
    if (rstn) begin
      exp_err = acc && (int'(a) >= NTW);
      if (acc && int'(a) < NTW) begin
        exp_q.push_back('{addr: a, data: d, be: be, clr: 1'b0});
        pushed++;
      end
      if (clr && clr_rem == 0) begin
        for (int i = 0; i < NTW; i++)
          exp_q.push_back('{addr: 8'(i), data: {4{cv}}, be: 4'hF, clr: 1'b1});
        clr_rem = NTW;
      end
    end
    @(negedge clk);
    #2;
  endtask

  task automatic idle(input int y);
    step(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0, y);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin idle(250); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d writes outstanding, expected 0", exp_q.size());
    end
    idle(250); idle(250);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    cpu_wr_valid = 0; cpu_wr_addr = 0; cpu_wr_data = 0; cpu_wr_be = 0;
    clr_req = 0; clr_value = 0; vga_pos_y = 0; draw_addr = 0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_ram_we", 64'(ram_we), 64'd0);
    chk("reset_wdata_be", {ram_wdata, ram_be}, 64'd0);
    chk("reset_level", 64'(fifo_level), 64'd0);
    chk("reset_busy_err", {clr_busy, addr_err}, 64'd0);
    rstn = 1'b1;
    #1;
    chk("reset_ready", 64'(cpu_wr_ready), 64'd1);

    // Write on an active line waits for the blank.
    step(1'b1, 8'd5, 32'h01020304, 4'hF, 1'b0, 8'd0, 100);
    repeat (5) idle(100);
    idle(239);
    chk("active_no_we", 64'(ram_we), 64'd0);
    idle(240);
    chk("blank_we", 64'(ram_we), 64'd1);
    chk("blank_addr_data", {ram_addr, ram_wdata}, {8'd5, 32'h01020304});
    idle(240);
    chk("single_pulse", 64'(ram_we), 64'd0);
    drain(20);

    // Blank write: strobe exactly two edges after the handshake.
    step(1'b1, 8'd10, 32'hCAFEF00D, 4'b0100, 1'b0, 8'd0, 250);
    chk("lat_n", 64'(ram_we), 64'd0);
    idle(250);
    chk("lat_n1", 64'(ram_we), 64'd0);
    idle(250);
    chk("lat_n2_we", 64'(ram_we), 64'd1);
    chk("lat_n2_be", 64'(ram_be), 64'(4'b0100));
    chk("lat_n2_level", 64'(fifo_level), 64'd0);
    drain(20);

    // Full FIFO while on an active line.
    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin
        chk("full_ready", 64'(cpu_wr_ready), 64'd0);
        chk("full_level", 64'(fifo_level), 64'd8);
      end
      step(1'b1, 8'(30 + i), $urandom, 4'($urandom), 1'b0, 8'd0, 50);
    end
    for (int i = 0; i < 8; i++) begin
      idle(240);
      chk("burst_we", 64'(ram_we), 64'd1);
    end
    idle(240);
    chk("burst_end", 64'(ram_we), 64'd0);
    drain(20);

    // Clear that runs out of blank after 100 writes, then resumes.
    clr_seen = 0;
    step(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'h2A, 245);
    repeat (101) idle(245);
    idle(100);
    chk("clr_paused_count", 64'(clr_seen), 64'd100);
    repeat (20) idle(100);
    chk("clr_still_paused", 64'(clr_seen), 64'd100);
    chk("clr_busy_paused", 64'(clr_busy), 64'd1);
    drain(400);
    chk("clr_total", 64'(clr_seen), 64'd240);
    chk("clr_done_busy", 64'(clr_busy), 64'd0);

    // Out-of-range address, then a write together with a clear.
    step(1'b1, 8'd240, 32'h12345678, 4'hF, 1'b0, 8'd0, 250);
    chk("bad_addr_err", 64'(addr_err), 64'd1);
    idle(250);
    chk("bad_addr_pulse", 64'(addr_err), 64'd0);
    chk("bad_addr_nowe", 64'(ram_we), 64'd0);
    step(1'b1, 8'd3, 32'hA5A5A5A5, 4'hF, 1'b1, 8'h55, 250);
    for (int n = 0; n < 600 && clr_rem > 0; n++) begin
      chk("clr_ready_low", 64'(cpu_wr_ready), 64'd0);
      step(1'b1, 8'($urandom_range(0, 239)), $urandom, 4'hF, 1'b0, 8'd0, 250);
    end
    drain(20);

    // Randomized traffic with occasional clears and random lines.
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 2) != 0), 8'($urandom_range(0, 255)), $urandom,
           4'($urandom), ($urandom_range(0, 199) == 0), 8'($urandom),
           ($urandom_range(0, 7) == 0) ? 239 + int'($urandom_range(0, 1))
                                        : int'($urandom_range(0, 524)));
    end
    drain(1200);

    // Reset in the middle of a drain.
    step(1'b1, 8'd20, 32'h11111111, 4'hF, 1'b0, 8'd0, 100);
    step(1'b1, 8'd21, 32'h22222222, 4'hF, 1'b0, 8'd0, 100);
    step(1'b1, 8'd22, 32'h33333333, 4'hF, 1'b0, 8'd0, 100);
    idle(250);
    chk("pre_reset_we", 64'(ram_we), 64'd1);
    rstn = 1'b0;
    #1;
    model_reset();
    chk("midreset_we", 64'(ram_we), 64'd0);
    chk("midreset_level", 64'(fifo_level), 64'd0);
    chk("midreset_busy", 64'(clr_busy), 64'd0);
    idle(250); idle(250);
    rstn = 1'b1;
    #1;
    chk("post_reset_ready", 64'(cpu_wr_ready), 64'd1);
    repeat (6) idle(250);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
